// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Exception / interrupt sequencer for the CP0 coprocessor. It looks at the
// instruction sitting in the MEM stage together with the forwarded CP0
// Status/Cause/EPC values. It picks at most one event per instruction:
// interrupt, synchronous exception or ERET. For the chosen event it drives a
// pipeline flush with a redirect PC, and it emits one-cycle commit pulses that
// CP0 uses to update EPC, Cause.ExcCode/BD and Status.EXL.
//
// Parameters
//   EXC_VECTOR    redirect PC used for every exception and interrupt
//   FLUSH_CYCLES  number of cycles flush_o is held per taken event (1..15)
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   mem_valid_i     MEM stage holds a real instruction
//   mem_stall_i     MEM stage stalled; nothing is detected while high
//   mem_pc_i        PC of the MEM-stage instruction
//   mem_in_delay_i  MEM instruction sits in a branch delay slot
//   exc_req_i       [0] syscall [1] reserved instr [2] trap [3] overflow [4] eret
//   status_i        forwarded CP0 Status
//   cause_i         forwarded CP0 Cause
//   epc_i           forwarded CP0 EPC (ERET target)
//   flush_o         flush IF..MEM and load new_pc_o
//   new_pc_o        redirect target
//   exc_commit_o    one-cycle pulse: CP0 latches EPC/code/BD and sets EXL
//   exc_code_o      ExcCode for Cause[6:2]
//   exc_epc_o       value for EPC
//   exc_bd_o        value for Cause[31]
//   eret_commit_o   one-cycle pulse: CP0 clears EXL
//   busy_o          controller is in its FLUSH window
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic [4:0]  exc_req_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        exc_commit_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic        eret_commit_o,
    output logic        busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;
    localparam logic [4:0] CODE_TRAP = 5'd13;

    // The counter holds the flush cycles still to come after the current one,
    // so an event loads FLUSH_CYCLES-1 and FLUSH leaves when it reads zero.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        exc_commit_q, exc_commit_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_epc_q, exc_epc_d;
    logic        exc_bd_q, exc_bd_d;
    logic        eret_commit_q, eret_commit_d;

    logic        int_pending;
    logic        sync_exc;
    logic        detect_en;
    logic [4:0]  sel_code;

    // Only the IE/EXL bits and the IP/IM byte take part in the interrupt test.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2],
                           cause_i[31:16], cause_i[7:0]};

    assign int_pending = status_i[0] && !status_i[1] &&
                         ((cause_i[15:8] & status_i[15:8]) != 8'h00);
    assign sync_exc    = (exc_req_i[3:0] != 4'b0000);
    assign detect_en   = mem_valid_i && !mem_stall_i;

    // Fixed priority encoder: interrupt > RI > overflow > trap > syscall.
    always_comb begin
        sel_code = CODE_SYS;
        if (int_pending) begin
            sel_code = CODE_INT;
        end else if (exc_req_i[1]) begin
            sel_code = CODE_RI;
        end else if (exc_req_i[3]) begin
            sel_code = CODE_OV;
        end else if (exc_req_i[2]) begin
            sel_code = CODE_TRAP;
        end
    end

    // Next-state logic. The redirect and exception payload registers hold
    // their value unless a new event is taken. The commit pulses and
    // flush default low.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_d       = 1'b0;
        new_pc_d      = new_pc_q;
        exc_commit_d  = 1'b0;
        exc_code_d    = exc_code_q;
        exc_epc_d     = exc_epc_q;
        exc_bd_d      = exc_bd_q;
        eret_commit_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (detect_en && (int_pending || sync_exc)) begin
                    state_d      = FLUSH;
                    cnt_d        = CNT_LOAD;
                    flush_d      = 1'b1;
                    new_pc_d     = EXC_VECTOR;
                    exc_commit_d = 1'b1;
                    exc_code_d   = sel_code;
                    // A delay-slot instruction restarts at its branch.
                    exc_epc_d    = mem_in_delay_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                    exc_bd_d     = mem_in_delay_i;
                end else if (detect_en && exc_req_i[4]) begin
                    state_d       = FLUSH;
                    cnt_d         = CNT_LOAD;
                    flush_d       = 1'b1;
                    new_pc_d      = epc_i;
                    eret_commit_d = 1'b1;
                end
            end
            FLUSH: begin
                // Inputs are ignored here. This also hides the cycle
                // before CP0 shows the updated EXL.
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'd0;
            exc_commit_q  <= 1'b0;
            exc_code_q    <= 5'd0;
            exc_epc_q     <= 32'd0;
            exc_bd_q      <= 1'b0;
            eret_commit_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            exc_commit_q  <= exc_commit_d;
            exc_code_q    <= exc_code_d;
            exc_epc_q     <= exc_epc_d;
            exc_bd_q      <= exc_bd_d;
            eret_commit_q <= eret_commit_d;
        end
    end

    assign flush_o       = flush_q;
    assign new_pc_o      = new_pc_q;
    assign exc_commit_o  = exc_commit_q;
    assign exc_code_o    = exc_code_q;
    assign exc_epc_o     = exc_epc_q;
    assign exc_bd_o      = exc_bd_q;
    assign eret_commit_o = eret_commit_q;
    assign busy_o        = (state_q == FLUSH);

endmodule
